inst_fetch_queue: RTL and testbench
===================================

# inst_fetch_queue

Parametrised instruction-fetch front end. It combines a direct-mapped word instruction cache, burst refill from the memory controller, predictor-steered PC generation and a circular instruction queue. It sits between the memory controller, the branch predictor, the dispatcher and the reorder buffer. Compared with the previous fetcher, it adds configurable cache and queue depth, configurable refill burst length, true head/tail FIFO pointers with simultaneous push/pop, byte-correct PC stepping (+4), and rollback that redirects the PC.

## Interface
- `ICACHE_IDX_W`, default 9: cache index width. The cache has 2^`ICACHE_IDX_W` one-word lines, indexed by `pc[ICACHE_IDX_W+1:2]`.
- `IQ_DEPTH`, default 8: queue entries. Must be a power of 2 and ≥2.
- `BURST_WORDS`, default 8: words per refill. Must be a power of 2.
- `RESET_PC`, default 32'h0: fetch start address.
- Clock and reset: one clock; reset is synchronous and active-high. Ports:
  - `clk_in` in 1: clock.
  - `rst_in` in 1: synchronous active-high reset.
  - `rdy_in` in 1: global enable. When low, all state holds.
- Memory controller:
  - `mem_req_out` out 1: refill request.
  - `mem_addr_out` out 32: burst base address.
  - `mem_word_valid_in` in 1: one word delivered this cycle.
  - `mem_word_in` in 32: the delivered word.
  - `mem_done_in` in 1: controller ended the burst early.
- Predictor:
  - `pc_to_predictor` out 32: current PC (combinational).
  - `inst_to_predictor` out 32: cache word at the PC, or 0 on miss.
  - `pred_taken_in` in 1: predicted taken.
  - `pred_imm_in` in 32: sign-extended offset.
- Dispatcher:
  - `disp_stall_in` in 1: downstream full.
  - `disp_valid_out` out 1: output entry valid.
  - `disp_inst_out` out 32: instruction.
  - `disp_pc_out` out 32: instruction PC.
  - `disp_pred_taken_out` out 1: prediction for this instruction.
  - `disp_fallthrough_out` out 32: pc+4.
- ROB:
  - `rollback_in` in 1: mispredict flush.
  - `rollback_pc_in` in 32: redirect target.

## Operation
- Cache line contents: valid bit, full 32-bit tag (the whole address), and instruction word.
- `hit` = valid[idx] and tag[idx] == pc.
- Enqueue: if `hit` and the queue is not full (count < `IQ_DEPTH`), write {inst, pc, pred_taken_in, pc+4} at tail, then tail++.
  - If `pred_taken_in`, next PC = pc + `pred_imm_in`; otherwise next PC = pc + 4.
  - All address arithmetic is 32-bit and wraps mod 2^32.
- Dequeue: if count > 0 and not `disp_stall_in`, register the head entry onto the `disp_*` outputs with `disp_valid_out`=1, then head++.
  - Otherwise `disp_valid_out`=0 and the other `disp_*` outputs are 0.
- Pointer and count rules: pointers wrap at `IQ_DEPTH`. Push and pop in the same cycle leave count unchanged. A pop from an empty queue, or a push into a full queue, never occurs.
- Refill FSM, states IDLE and REFILL:
  - IDLE → REFILL when there is a miss. On that transition: base = pc with the low log2(`BURST_WORDS`)+2 bits cleared; `mem_addr_out`=base; `mem_req_out`=1; word counter=0.
  - In REFILL, each `mem_word_valid_in` writes line idx(base + 4·cnt) with tag base + 4·cnt, valid=1, then cnt++.
  - REFILL → IDLE, with `mem_req_out`=0, when the last word (cnt = `BURST_WORDS`-1) is written, or when `mem_done_in` is seen.
  - A word and `mem_done_in` arriving in the same cycle: the word is written.
- Rollback has priority over enqueue and dequeue in the same cycle:
  - head = tail = count = 0; PC = `rollback_pc_in`; `disp_valid_out`=0.
  - An in-flight refill continues and its words are still written. Cache contents are non-speculative.
- Misses during REFILL do not restart the burst. After the burst returns to IDLE, a still-missing PC starts a new burst.
- Reset values:
  - All `disp_*` outputs = 0.
  - `mem_req_out`=0, `mem_addr_out`=0.
  - PC = `RESET_PC`; FSM = IDLE.
  - All valid bits = 0; queue empty.

## Timing
- Hit path: PC hits in cycle N → entry enqueued at edge N → popped at edge N+1 → `disp_valid_out` high during N+2. There is no queue bypass.
- Miss path: miss in cycle N → `mem_req_out` high from cycle N+1. A word written at edge M can be hit in cycle M+1.
- Throughput: one instruction per cycle sustained when hits are continuous and `disp_stall_in`=0.
- `disp_stall_in` is sampled in the pop cycle. A stall while the queue is full blocks enqueue and freezes the PC.
- Rollback in cycle R: the first redirected fetch lookup occurs in cycle R+1; the earliest dispatch is R+3.

## Structure
- The shared constants package holds `ADDR_W`=32, `INST_W`=32, `INST_NOP`, and the queue entry typedef {inst, pc, taken, fallthrough}.
- One sub-module: `iq_fifo`, a parametrised circular FIFO (push, pop, flush, full, empty, count) instanced with `IQ_DEPTH`.
- The cache arrays and the refill FSM stay in the top level.

## Test plan
- Reset, then preload words 0x00000013 at 0x0–0x1C via an 8-word burst → `mem_addr_out`=0x0. Eight dispatches follow with pc 0x0, 0x4, …, 0x1C and fallthrough = pc+4.
- Cached branch at 0x8 with `pred_taken_in`=1, `pred_imm_in`=0x100 → next dispatched pc = 0x108; the 0x8 entry has `disp_pred_taken_out`=1.
- Hold `disp_stall_in`=1 for 20 cycles on a hot loop → count saturates at `IQ_DEPTH`, the PC freezes, and there is no lost or duplicated pc after release.
- Assert `rollback_in` with pc 0x40 while the queue is half full and a refill is in progress → next cycle `disp_valid_out`=0; the burst completes; the first dispatch is pc 0x40.
- Assert `mem_done_in` after 3 words of a burst at 0x20 → lines 0x20–0x28 are valid and 0x2C misses. A new burst at base 0x20 is issued.
- Drop `rdy_in` for 5 cycles mid-stream → all outputs and pointers hold, and the dispatch sequence resumes unchanged.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch front end.
//   ADDR_W / INST_W : address and instruction widths
//   INST_NOP        : canonical no-op encoding (addi x0,x0,0)
//   iq_entry_t      : one instruction-queue slot {inst, pc, taken, fallthrough}
//   fetch_state_t   : refill FSM states
package inst_fetch_queue_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] fallthrough;
  } iq_entry_t;

  typedef enum logic {
    FSM_IDLE,
    FSM_REFILL
  } fetch_state_t;

endpackage

// File: rtl/iq_fifo.sv
// Circular instruction queue with head/tail pointers and an occupancy count.
// Ports:
//   clk_in, rst_in : clock, synchronous active-high reset
//   en             : global enable; all state holds when low
//   push, pop      : enqueue at tail / advance head (may occur together)
//   flush          : empty the queue (wins over push and pop)
//   wdata          : entry written at tail on push
//   rdata          : entry at head (combinational)
//   full, empty    : occupancy flags
module iq_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      en,
  input  logic      push,
  input  logic      pop,
  input  logic      flush,
  input  iq_entry_t wdata,
  output iq_entry_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  iq_entry_t          slots [DEPTH];
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [CNT_W-1:0]   count;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (en) begin
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (en && push && !flush) slots[tail] <= wdata;
  end

  assign rdata = slots[head];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: direct-mapped one-word-per-line I-cache with
// burst refill, predictor-steered PC and a circular instruction queue.
// Ports:
//   clk_in, rst_in, rdy_in          : clock, sync reset, global enable
//   mem_req_out, mem_addr_out       : refill request and burst base address
//   mem_word_valid_in, mem_word_in  : refill word strobe and data
//   mem_done_in                     : controller ended the burst early
//   pc_to_predictor, inst_to_predictor, pred_taken_in, pred_imm_in : predictor
//   disp_stall_in, disp_*_out       : registered dispatch port
//   rollback_in, rollback_pc_in     : mispredict flush and redirect
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int          ICACHE_IDX_W = 9,
  parameter int          IQ_DEPTH     = 8,
  parameter int          BURST_WORDS  = 8,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  output logic        mem_req_out,
  output logic [31:0] mem_addr_out,
  input  logic        mem_word_valid_in,
  input  logic [31:0] mem_word_in,
  input  logic        mem_done_in,
  output logic [31:0] pc_to_predictor,
  output logic [31:0] inst_to_predictor,
  input  logic        pred_taken_in,
  input  logic [31:0] pred_imm_in,
  input  logic        disp_stall_in,
  output logic        disp_valid_out,
  output logic [31:0] disp_inst_out,
  output logic [31:0] disp_pc_out,
  output logic        disp_pred_taken_out,
  output logic [31:0] disp_fallthrough_out,
  input  logic        rollback_in,
  input  logic [31:0] rollback_pc_in
);

  localparam int LINES  = 1 << ICACHE_IDX_W;
  localparam int OFF_W  = $clog2(BURST_WORDS) + 2;
  localparam int BCNT_W = (BURST_WORDS > 1) ? $clog2(BURST_WORDS) : 1;

  logic [ADDR_W-1:0]       pc;
  logic [LINES-1:0]        line_valid;
  logic [ADDR_W-1:0]       line_tag  [LINES];
  logic [INST_W-1:0]       line_data [LINES];
  fetch_state_t            state;
  logic [BCNT_W-1:0]       wcnt;

  logic [ICACHE_IDX_W-1:0] idx;
  logic                    hit;
  logic [ADDR_W-1:0]       fill_addr;
  logic [ICACHE_IDX_W-1:0] fill_idx;
  logic                    fill_last;
  logic                    fill_we;

  logic                    iq_push;
  logic                    iq_pop;
  logic                    iq_full;
  logic                    iq_empty;
  iq_entry_t               iq_wdata;
  iq_entry_t               iq_head;

  // Lookup: the tag holds the full address, so any mismatch is a miss.
  assign idx               = pc[ICACHE_IDX_W+1:2];
  assign hit               = line_valid[idx] && (line_tag[idx] == pc);
  assign pc_to_predictor   = pc;
  assign inst_to_predictor = hit ? line_data[idx] : '0;

  // mem_addr_out doubles as the burst base register.
  assign fill_addr = mem_addr_out + ADDR_W'({wcnt, 2'b00});
  assign fill_idx  = fill_addr[ICACHE_IDX_W+1:2];
  assign fill_last = (wcnt == BCNT_W'(BURST_WORDS - 1));
  assign fill_we   = rdy_in && (state == FSM_REFILL) && mem_word_valid_in;

  // Rollback suppresses both queue operations; the FIFO flush empties it.
  assign iq_push = hit && !iq_full && !rollback_in;
  assign iq_pop  = !iq_empty && !disp_stall_in && !rollback_in;

  assign iq_wdata = '{inst: line_data[idx], pc: pc, taken: pred_taken_in,
                      fallthrough: pc + 32'd4};

  iq_fifo #(
    .DEPTH (IQ_DEPTH)
  ) u_iq (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .en     (rdy_in),
    .push   (iq_push),
    .pop    (iq_pop),
    .flush  (rollback_in),
    .wdata  (iq_wdata),
    .rdata  (iq_head),
    .full   (iq_full),
    .empty  (iq_empty)
  );

  // ---- fetch stage: PC generation ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pc <= RESET_PC;
    end else if (rdy_in) begin
      if (rollback_in)  pc <= rollback_pc_in;
      else if (iq_push) pc <= pred_taken_in ? pc + pred_imm_in : pc + 32'd4;
    end
  end

  // ---- refill FSM: a miss seen in IDLE starts one burst; misses in REFILL wait ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= FSM_IDLE;
      mem_req_out  <= 1'b0;
      mem_addr_out <= '0;
      wcnt         <= '0;
      line_valid   <= '0;
    end else if (rdy_in) begin
      case (state)
        FSM_IDLE: begin
          if (!hit) begin
            state        <= FSM_REFILL;
            mem_req_out  <= 1'b1;
            mem_addr_out <= {pc[ADDR_W-1:OFF_W], OFF_W'(0)};
            wcnt         <= '0;
          end
        end
        FSM_REFILL: begin
          if (mem_word_valid_in) begin
            line_valid[fill_idx] <= 1'b1;
            wcnt                 <= wcnt + 1'b1;
          end
          // A word arriving together with done is still written above.
          if ((mem_word_valid_in && fill_last) || mem_done_in) begin
            state       <= FSM_IDLE;
            mem_req_out <= 1'b0;
          end
        end
        default: state <= FSM_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      line_tag[fill_idx]  <= fill_addr;
      line_data[fill_idx] <= mem_word_in;
    end
  end

  // ---- dispatch stage: registered head entry, zeros when nothing pops ----
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      disp_valid_out       <= 1'b0;
      disp_inst_out        <= '0;
      disp_pc_out          <= '0;
      disp_pred_taken_out  <= 1'b0;
      disp_fallthrough_out <= '0;
    end else if (rdy_in) begin
      if (iq_pop) begin
        disp_valid_out       <= 1'b1;
        disp_inst_out        <= iq_head.inst;
        disp_pc_out          <= iq_head.pc;
        disp_pred_taken_out  <= iq_head.taken;
        disp_fallthrough_out <= iq_head.fallthrough;
      end else begin
        disp_valid_out       <= 1'b0;
        disp_inst_out        <= '0;
        disp_pc_out          <= '0;
        disp_pred_taken_out  <= 1'b0;
        disp_fallthrough_out <= '0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int IDX_W = 9;
  localparam int DEPTH = 8;
  localparam int BW    = 8;
  localparam int LINES = 1 << IDX_W;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        mem_req_out;
  logic [31:0] mem_addr_out;
  logic        mem_word_valid_in = 1'b0;
  logic [31:0] mem_word_in = '0;
  logic        mem_done_in = 1'b0;
  logic [31:0] pc_to_predictor;
  logic [31:0] inst_to_predictor;
  logic        pred_taken_in = 1'b0;
  logic [31:0] pred_imm_in = '0;
  logic        disp_stall_in = 1'b0;
  logic        disp_valid_out;
  logic [31:0] disp_inst_out;
  logic [31:0] disp_pc_out;
  logic        disp_pred_taken_out;
  logic [31:0] disp_fallthrough_out;
  logic        rollback_in = 1'b0;
  logic [31:0] rollback_pc_in = '0;

  always #5 clk_in = ~clk_in;

  inst_fetch_queue #(
    .ICACHE_IDX_W (IDX_W),
    .IQ_DEPTH     (DEPTH),
    .BURST_WORDS  (BW),
    .RESET_PC     (32'h0)
  ) dut (
    .clk_in               (clk_in),
    .rst_in               (rst_in),
    .rdy_in               (rdy_in),
    .mem_req_out          (mem_req_out),
    .mem_addr_out         (mem_addr_out),
    .mem_word_valid_in    (mem_word_valid_in),
    .mem_word_in          (mem_word_in),
    .mem_done_in          (mem_done_in),
    .pc_to_predictor      (pc_to_predictor),
    .inst_to_predictor    (inst_to_predictor),
    .pred_taken_in        (pred_taken_in),
    .pred_imm_in          (pred_imm_in),
    .disp_stall_in        (disp_stall_in),
    .disp_valid_out       (disp_valid_out),
    .disp_inst_out        (disp_inst_out),
    .disp_pc_out          (disp_pc_out),
    .disp_pred_taken_out  (disp_pred_taken_out),
    .disp_fallthrough_out (disp_fallthrough_out),
    .rollback_in          (rollback_in),
    .rollback_pc_in       (rollback_pc_in)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Backing memory image seen through the refill port.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'h40) ? 32'h0000_0013 : ({a[29:0], 2'b11} ^ 32'h5A00_0000);
  endfunction

  // Stimulus knobs (written only by the main initial block / cycle task)
  int pmode = 0;   // 0 none, 1 branch at 0x8, 2 loop at 0x1C, 3 random
  int mmode = 0;   // 0 every cycle, 1 early done on first 0x20 burst, 2 slow, 3 random
  bit rmode = 0;   // random stall/rollback/rdy
  bit done_used = 0;
  int slow_t = 0;
  int rdy_low_left = 0;

  // Written only by the model process
  int        mc_cnt = 0;
  iq_entry_t dlog[$];
  logic [31:0] blog[$];
  bit        req_prev = 0;

  // ---------------- behavioural reference model ----------------
  logic [LINES-1:0] m_vld;
  logic [31:0]      m_tag [LINES];
  logic [31:0]      m_dat [LINES];
  iq_entry_t        m_q[$];
  logic [31:0]      m_pc;
  bit               m_refill, m_req, m_dvld, m_live = 0;
  logic [31:0]      m_base;
  int               m_cnt;
  iq_entry_t        m_disp;

  always @(negedge clk_in) begin : model
    int          li, wi;
    bit          hit, do_pop, do_push;
    logic [31:0] cur_pc, cur_inst, a;
    iq_entry_t   e;
    cur_pc   = m_pc;
    li       = int'((cur_pc / 4) % LINES);
    hit      = m_vld[li] && (m_tag[li] == cur_pc);
    cur_inst = hit ? m_dat[li] : 32'h0;
    if (m_live) begin
      check("pc_to_predictor", pc_to_predictor, cur_pc);
      check("inst_to_predictor", inst_to_predictor, cur_inst);
      check("mem_req_out", 32'(mem_req_out), 32'(m_req));
      check("mem_addr_out", mem_addr_out, m_base);
      check("disp_valid_out", 32'(disp_valid_out), 32'(m_dvld));
      check("disp_inst_out", disp_inst_out, m_disp.inst);
      check("disp_pc_out", disp_pc_out, m_disp.pc);
      check("disp_pred_taken_out", 32'(disp_pred_taken_out), 32'(m_disp.taken));
      check("disp_fallthrough_out", disp_fallthrough_out, m_disp.fallthrough);
    end
    if (disp_valid_out) begin
      e = '{inst: disp_inst_out, pc: disp_pc_out, taken: disp_pred_taken_out,
            fallthrough: disp_fallthrough_out};
      dlog.push_back(e);
    end
    if (mem_req_out && !req_prev) blog.push_back(mem_addr_out);
    req_prev = mem_req_out;
    if (!mem_req_out) mc_cnt = 0;
    else if (mem_word_valid_in && rdy_in && !rst_in) mc_cnt++;

    if (rst_in) begin
      m_vld = '0; m_q.delete(); m_pc = 32'h0; m_refill = 0; m_req = 0;
      m_base = 32'h0; m_cnt = 0; m_dvld = 0; m_disp = '0; m_live = 1;
    end else if (rdy_in) begin
      // queue and PC
      if (rollback_in) begin
        m_q.delete(); m_pc = rollback_pc_in; m_dvld = 0; m_disp = '0;
      end else begin
        do_pop  = (m_q.size() > 0) && !disp_stall_in;
        do_push = hit && (m_q.size() < DEPTH);
        if (do_pop) begin m_disp = m_q.pop_front(); m_dvld = 1; end
        else begin m_disp = '0; m_dvld = 0; end
        if (do_push) begin
          e = '{inst: cur_inst, pc: cur_pc, taken: pred_taken_in, fallthrough: cur_pc + 32'd4};
          m_q.push_back(e);
          m_pc = pred_taken_in ? cur_pc + pred_imm_in : cur_pc + 32'd4;
        end
      end
      // cache refill
      if (m_refill) begin
        if (mem_word_valid_in) begin
          a  = m_base + 32'(4 * m_cnt);
          wi = int'((a / 4) % LINES);
          m_vld[wi] = 1'b1; m_tag[wi] = a; m_dat[wi] = mem_word_in;
          m_cnt++;
        end
        if (m_cnt == BW || mem_done_in) begin m_refill = 0; m_req = 0; end
      end else if (!hit) begin
        m_refill = 1; m_req = 1; m_cnt = 0;
        m_base = cur_pc - (cur_pc % (BW * 4));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    bit give;
    logic [31:0] tgt;
    @(posedge clk_in);
    #1;
    slow_t++;
    mem_word_valid_in = 1'b0;
    mem_done_in       = 1'b0;
    mem_word_in       = '0;
    if (mem_req_out && mc_cnt < BW) begin
      give = 1'b0;
      case (mmode)
        0: give = 1'b1;
        1: if (mem_addr_out == 32'h20 && !done_used && mc_cnt == 3) begin
             mem_done_in = 1'b1; done_used = 1'b1;
           end else give = 1'b1;
        2: give = (slow_t % 3 == 0);
        default: begin
          give        = ($urandom_range(0, 9) < 7);
          mem_done_in = ($urandom_range(0, 59) == 0);
        end
      endcase
      if (give) begin
        mem_word_valid_in = 1'b1;
        mem_word_in       = mem_word(mem_addr_out + 32'(4 * mc_cnt));
      end
    end
    case (pmode)
      0: begin pred_taken_in = 1'b0; pred_imm_in = 32'h0; end
      1: begin pred_taken_in = (pc_to_predictor == 32'h8);  pred_imm_in = 32'h100; end
      2: begin pred_taken_in = (pc_to_predictor == 32'h1C); pred_imm_in = 32'hFFFF_FFE4; end
      default: begin
        pred_taken_in = ($urandom_range(0, 3) == 0);
        tgt           = 32'($urandom_range(0, 127)) * 32'd4;
        pred_imm_in   = tgt - pc_to_predictor;
      end
    endcase
    if (rmode) begin
      disp_stall_in  = ($urandom_range(0, 9) < 3);
      rollback_in    = ($urandom_range(0, 49) == 0);
      rollback_pc_in = 32'($urandom_range(0, 127)) * 32'd4;
      if (rdy_low_left > 0) begin rdy_in = 1'b0; rdy_low_left--; end
      else if ($urandom_range(0, 39) == 0) begin rdy_in = 1'b0; rdy_low_left = $urandom_range(0, 4); end
      else rdy_in = 1'b1;
    end
  endtask

  task automatic do_rollback(input logic [31:0] target);
    rollback_pc_in = target;
    rollback_in    = 1'b1;
    cycle();
    rollback_in    = 1'b0;
    dlog.delete();
  endtask

  initial begin
    logic [31:0] p0;
    // Reset
    cycle();
    cycle();
    check("rst_pc", pc_to_predictor, 32'h0);
    check("rst_mem_req", 32'(mem_req_out), 32'h0);
    check("rst_mem_addr", mem_addr_out, 32'h0);
    check("rst_disp_valid", 32'(disp_valid_out), 32'h0);
    rst_in = 1'b0;

    // Preload via 8-word burst; early done on first 0x20 burst
    mmode = 1;
    for (int i = 0; i < 100; i++) cycle();
    check("p1_burst_count", 32'(blog.size() >= 3), 32'h1);
    if (blog.size() >= 3) begin
      check("p1_burst0", blog[0], 32'h0);
      check("p1_burst1", blog[1], 32'h20);
      check("p1_burst2", blog[2], 32'h20);
    end
    check("p1_disp_count", 32'(dlog.size() >= 12), 32'h1);
    if (dlog.size() >= 12) begin
      for (int i = 0; i < 12; i++) check("p1_disp_pc", dlog[i].pc, 32'(4 * i));
      check("p1_inst0", dlog[0].inst, 32'h0000_0013);
      check("p1_ft0", dlog[0].fallthrough, 32'h4);
      check("p1_ft7", dlog[7].fallthrough, 32'h20);
    end

    // Predicted-taken branch at 0x8
    mmode = 0; pmode = 1;
    do_rollback(32'h0);
    for (int i = 0; i < 60; i++) cycle();
    check("p2_disp_count", 32'(dlog.size() >= 4), 32'h1);
    if (dlog.size() >= 4) begin
      check("p2_pc0", dlog[0].pc, 32'h0);
      check("p2_pc2", dlog[2].pc, 32'h8);
      check("p2_taken2", 32'(dlog[2].taken), 32'h1);
      check("p2_taken1", 32'(dlog[1].taken), 32'h0);
      check("p2_pc3", dlog[3].pc, 32'h108);
    end

    // Stall on a hot loop 0x0..0x1C
    pmode = 2; disp_stall_in = 1'b1;
    do_rollback(32'h0);
    for (int i = 0; i < 20; i++) cycle();
    check("p3_pc_frozen", pc_to_predictor, 32'h0);
    check("p3_no_disp", 32'(disp_valid_out), 32'h0);
    disp_stall_in = 1'b0;
    dlog.delete();
    for (int i = 0; i < 30; i++) cycle();
    check("p3_disp_count", 32'(dlog.size() >= 10), 32'h1);
    if (dlog.size() >= 10)
      for (int i = 0; i < 10; i++) check("p3_disp_pc", dlog[i].pc, 32'((4 * i) % 32));

    // Rollback during refill with entries queued
    pmode = 0; mmode = 2; disp_stall_in = 1'b1;
    do_rollback(32'h400);
    for (int i = 0; i < 20 && !mem_req_out; i++) cycle();
    check("p4_req_rise", 32'(mem_req_out), 32'h1);
    for (int i = 0; i < 12; i++) cycle();
    disp_stall_in = 1'b0;
    do_rollback(32'h40);
    check("p4_disp_cleared", 32'(disp_valid_out), 32'h0);
    check("p4_refill_continues", 32'(mem_req_out), 32'h1);
    for (int i = 0; i < 120; i++) cycle();
    check("p4_disp_count", 32'(dlog.size() >= 1), 32'h1);
    if (dlog.size() >= 1) check("p4_first_pc", dlog[0].pc, 32'h40);

    // rdy_in low for 5 cycles mid-stream
    mmode = 0;
    for (int i = 0; i < 10; i++) cycle();
    rdy_in = 1'b0;
    p0 = pc_to_predictor;
    for (int i = 0; i < 5; i++) cycle();
    check("p5_pc_hold", pc_to_predictor, p0);
    rdy_in = 1'b1;
    for (int i = 0; i < 10; i++) cycle();

    // Randomized traffic, with one mid-run reset
    pmode = 3; mmode = 3; rmode = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) rst_in = 1'b1;
      cycle();
      if (i == 1500) rst_in = 1'b0;
    end
    rmode = 0; rdy_in = 1'b1; rollback_in = 1'b0; disp_stall_in = 1'b0;
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
